toeplitz_seed_dump: RTL and testbench
=====================================

# toeplitz_seed_dump

- Streams the Toeplitz seed currently held in the hashing datapath back out as BS-bit words, in the same word order and packing as the hex seed files (c-file words first, then r-file words).
- Inverts the row-vector transform exactly: bit-reversal, and the one-bit shift that drops the corner bit shared with the column.
- Sits beside the Toeplitz core. Software reads the active seed over a valid/ready stream for logging or cross-check against the source files.

## Interface
- BS, 64: word width; also the file word width.
- N, 256: row vector length; must be a multiple of BS. Non-multiple gives an elaboration error. XSZ = N/BS.
- L, 128: column vector length; must be a multiple of BS. Non-multiple gives an elaboration error. YSZ = L/BS.
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to dump; sampled only in IDLE.
- rrow0  in  N  reversed-order row vector, as driven into the core.
- col0  in  L  column vector, as driven into the core.
- busy  out  1  high from the cycle after accepted start until the done pulse, inclusive.
- dout  out  BS  current output word.
- dout_valid  out  1  dout holds a valid word.
- dout_ready  in  1  sink accepts dout when dout_valid && dout_ready (handshake).
- dout_sel  out  1  0 = column word, 1 = row word.
- dout_last  out  1  high with the final row word.
- done  out  1  one-cycle pulse after the final handshake.

## Operation
- Snapshot: on accepted start, rrow0 and col0 are captured into internal registers. Later input changes do not affect the dump in progress.
- Column words: c[k] = col0[L-1-k*BS -: BS], for k = 0..YSZ-1.
- Row reconstruction: the flat row image rflat[N-1:0] is rebuilt as:
  - rflat[j] = rrow0[N-2-j], for j = 0..N-2.
  - rflat[N-1] = col0[L-1] (shared corner bit).
  - rrow0[N-1] is ignored.
- Row words: r[k] = rflat[N-1-k*BS -: BS], for k = 0..XSZ-1.
- FSM states: IDLE, COL, ROW, FIN.
  - IDLE to COL on start.
  - COL to ROW on handshake of c[YSZ-1].
  - ROW to FIN on handshake of r[XSZ-1].
  - FIN to IDLE unconditionally after one cycle; done = 1 during FIN.
- Word counter: width $clog2(max(XSZ,YSZ)+1). Cleared on each state entry; increments on handshake only.
- dout_valid is high in COL and ROW only.
- Output registers: dout, dout_sel and dout_last are registered. They hold stable while dout_valid && !dout_ready.
- Ignored requests: start is ignored in COL, ROW and FIN, with no queuing.
- Reset values: state IDLE, counter 0, dout 0, dout_valid 0, dout_sel 0, dout_last 0, busy 0, done 0.
- Reset mid-dump aborts immediately (asynchronous), with no done pulse. The next start restarts from c[0].

## Timing
- Start accepted at edge t: busy = 1, dout_valid = 1 and dout = c[0] from t+1.
- With dout_ready held high, one word per cycle:
  - c[k] at t+1+k.
  - r[k] at t+1+YSZ+k.
  - dout_last at t+YSZ+XSZ.
  - done at t+YSZ+XSZ+1.
  - busy low at t+YSZ+XSZ+2.
- Each cycle of dout_ready = 0 extends the schedule by one cycle. There are no bubbles otherwise.
- A start in the same cycle as done is ignored. The earliest next accepted start is the cycle after done.

## Test plan
Defaults BS=64, N=256, L=128 (XSZ=4, YSZ=2); dout_ready = 1 unless stated.
- Basic packing:
  - Stimulus: col0 = {64'h8000_0000_0000_00AA, 64'h0000_0000_0000_0055}; rrow0 bit N-2 = 1, all other bits 0; start pulse.
  - Required: words 8000_0000_0000_00AA, 0000_0000_0000_0055, 8000_0000_0000_0000, 0, 0, 0000_0000_0000_0001.
  - Required: dout_sel = 0,0,1,1,1,1; dout_last on word 6 only; done one cycle after word 6.
- Dropped bit and corner:
  - Stimulus: rrow0 = all ones, col0 = 0.
  - Required: row words 7FFF_FFFF_FFFF_FFFF, then FFFF_FFFF_FFFF_FFFF three times (rrow0[255] ignored).
- Backpressure:
  - Stimulus: dout_ready = 0 for 3 cycles while word 2 (c[1]) is presented.
  - Required: dout, dout_sel and dout_last stable throughout the stall; all 6 words delivered once, in order; done 3 cycles later than the unstalled run.
- Snapshot and start-while-busy:
  - Stimulus: change col0 and rrow0 and pulse start during COL.
  - Required: words match the values captured at the accepted start; no second dump.
- Mid-dump reset:
  - Stimulus: assert rst after 2 handshakes.
  - Required: dout_valid, busy and done go to 0 immediately; no done pulse.
  - Then a new start yields the full 6-word sequence beginning at c[0].
- Non-default parameters:
  - Stimulus: BS=32, N=96, L=64 with random vectors.
  - Required: 5 words matching a bench model of the packing formulas.

Source files
------------

// File: rtl/toeplitz_seed_dump_if.sv
// Output word stream of the Toeplitz seed dump.
//   dout        : current BS-bit seed word
//   dout_valid  : dout holds a valid word
//   dout_ready  : sink accepts dout when dout_valid && dout_ready
//   dout_sel    : 0 = column word, 1 = row word
//   dout_last   : final row word of the dump
// master = the dump block (word source), slave = the sink.
interface toeplitz_seed_dump_if #(
  parameter int BS = 64
);
  logic [BS-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          dout_sel;
  logic          dout_last;

  modport master (
    output dout, dout_valid, dout_sel, dout_last,
    input  dout_ready
  );

  modport slave (
    input  dout, dout_valid, dout_sel, dout_last,
    output dout_ready
  );
endinterface

// File: rtl/toeplitz_seed_dump.sv
// Streams the Toeplitz seed held by the hashing datapath back out as BS-bit
// words in hex-seed-file order: column words c[0..YSZ-1], then row words
// r[0..XSZ-1]. The row image is rebuilt from the reversed row vector by
// undoing the bit reversal and restoring the corner bit shared with the column.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   start     : one-cycle dump request, honoured only when idle
//   rrow0     : reversed-order row vector (N bits) as driven into the core
//   col0      : column vector (L bits) as driven into the core
//   busy      : dump in progress (through the done cycle)
//   done      : one-cycle pulse after the final word handshake
//   dbus      : output word stream (dout/valid/ready/sel/last)
module toeplitz_seed_dump #(
  parameter int BS = 64,
  parameter int N  = 256,
  parameter int L  = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N-1:0]          rrow0,
  input  logic [L-1:0]          col0,
  output logic                  busy,
  output logic                  done,
  toeplitz_seed_dump_if.master  dbus
);

  localparam int XSZ   = N / BS;
  localparam int YSZ   = L / BS;
  localparam int MAXSZ = (XSZ > YSZ) ? XSZ : YSZ;
  localparam int CW    = $clog2(MAXSZ + 1);

  if (N % BS != 0) begin : g_bad_n
    $error("toeplitz_seed_dump: N must be a multiple of BS");
  end
  if (L % BS != 0) begin : g_bad_l
    $error("toeplitz_seed_dump: L must be a multiple of BS");
  end

  typedef enum logic [1:0] {IDLE, COL, ROW, FIN} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next, cnt_inc;
  logic [L-1:0]  col_reg;
  logic [N-1:0]  rflat_reg, rflat_in;
  logic [BS-1:0] dout_reg, dout_next;
  logic          sel_reg, sel_next;
  logic          last_reg, last_next;
  logic          capture, valid, hs;
  logic [BS-1:0] col_words [YSZ];
  logic [BS-1:0] row_words [XSZ];
  logic [BS-1:0] col_at_inc, row_at_inc;

  // The top bit of rrow0 is the corner bit, which the core also gets from
  // the column; the column copy is the authoritative one.
  logic unused_rrow_msb;
  assign unused_rrow_msb = rrow0[N-1];

  // Flat row image: undo the reversal, corner bit comes from the column MSB.
  for (genvar gi = 0; gi < N - 1; gi++) begin : g_rflat
    assign rflat_in[gi] = rrow0[N-2-gi];
  end
  assign rflat_in[N-1] = col0[L-1];

  for (genvar gi = 0; gi < YSZ; gi++) begin : g_col_words
    assign col_words[gi] = col_reg[L-1-gi*BS -: BS];
  end
  for (genvar gi = 0; gi < XSZ; gi++) begin : g_row_words
    assign row_words[gi] = rflat_reg[N-1-gi*BS -: BS];
  end

  // The output word is registered, so the mux looks one word ahead.
  assign cnt_inc = cnt_reg + CW'(1);

  always_comb begin
    col_at_inc = '0;
    row_at_inc = '0;
    for (int i = 0; i < YSZ; i++)
      if (cnt_inc == CW'(i)) col_at_inc = col_words[i];
    for (int i = 0; i < XSZ; i++)
      if (cnt_inc == CW'(i)) row_at_inc = row_words[i];
  end

  assign valid = (state_reg == COL) || (state_reg == ROW);
  assign hs    = valid && dbus.dout_ready;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    dout_next  = dout_reg;
    sel_next   = sel_reg;
    last_next  = last_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          capture    = 1'b1;
          state_next = COL;
          cnt_next   = '0;
          dout_next  = col0[L-1 -: BS];  // c[0] straight from the inputs
          sel_next   = 1'b0;
          last_next  = 1'b0;
        end
      end
      COL: begin
        if (hs) begin
          if (cnt_reg == CW'(YSZ - 1)) begin
            state_next = ROW;
            cnt_next   = '0;
            dout_next  = row_words[0];
            sel_next   = 1'b1;
            last_next  = (XSZ == 1);
          end else begin
            cnt_next  = cnt_inc;
            dout_next = col_at_inc;
          end
        end
      end
      ROW: begin
        if (hs) begin
          if (cnt_reg == CW'(XSZ - 1)) begin
            state_next = FIN;
            cnt_next   = '0;
            last_next  = 1'b0;
          end else begin
            cnt_next  = cnt_inc;
            dout_next = row_at_inc;
            last_next = (cnt_inc == CW'(XSZ - 1));
          end
        end
      end
      FIN: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      dout_reg  <= '0;
      sel_reg   <= 1'b0;
      last_reg  <= 1'b0;
      col_reg   <= '0;
      rflat_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      dout_reg  <= dout_next;
      sel_reg   <= sel_next;
      last_reg  <= last_next;
      if (capture) begin
        col_reg   <= col0;
        rflat_reg <= rflat_in;
      end
    end
  end

  assign busy            = (state_reg != IDLE);
  assign done            = (state_reg == FIN);
  assign dbus.dout       = dout_reg;
  assign dbus.dout_valid = valid;
  assign dbus.dout_sel   = sel_reg;
  assign dbus.dout_last  = last_reg;

endmodule

// File: tb/tb_toeplitz_seed_dump.sv
module tb_toeplitz_seed_dump;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start_a, start_b;
  logic [255:0] row_a;
  logic [127:0] col_a;
  logic [95:0]  row_b;
  logic [63:0]  col_b;
  logic         busy_a, done_a, busy_b, done_b;

  toeplitz_seed_dump_if #(.BS(64)) bus_a ();
  toeplitz_seed_dump_if #(.BS(32)) bus_b ();

  toeplitz_seed_dump #(.BS(64), .N(256), .L(128)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .rrow0(row_a), .col0(col_a),
    .busy(busy_a), .done(done_a), .dbus(bus_a)
  );

  toeplitz_seed_dump #(.BS(32), .N(96), .L(64)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .rrow0(row_b), .col0(col_b),
    .busy(busy_b), .done(done_b), .dbus(bus_b)
  );

  int passed = 0;
  int total  = 0;

  // Expected word list of the current dump
  logic [63:0] exp_w [8];
  int          nw;
  int          ysz_m;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: column words are successive BS-bit slices from the top of col;
  // the row image is the un-reversed row with the corner bit from col's MSB.
  function automatic void model(input int bs, input int n, input int l,
                                input logic [255:0] row, input logic [255:0] col);
    logic [255:0] rflat;
    logic [255:0] m;
    rflat = '0;
    m = {256{1'b1}} >> (256 - bs);
    for (int j = 0; j < n - 1; j++) rflat[j] = row[n-2-j];
    rflat[n-1] = col[l-1];
    nw = 0;
    ysz_m = l / bs;
    for (int k = 0; k < l / bs; k++) begin
      exp_w[nw] = 64'((col >> (l - (k + 1) * bs)) & m);
      nw++;
    end
    for (int k = 0; k < n / bs; k++) begin
      exp_w[nw] = 64'((rflat >> (n - (k + 1) * bs)) & m);
      nw++;
    end
  endfunction

  task automatic set_basic();
    col_a = {64'h8000_0000_0000_00AA, 64'h0000_0000_0000_0055};
    row_a = '0;
    row_a[254] = 1'b1;
    exp_w[0] = 64'h8000_0000_0000_00AA;
    exp_w[1] = 64'h0000_0000_0000_0055;
    exp_w[2] = 64'h8000_0000_0000_0000;
    exp_w[3] = 64'h0;
    exp_w[4] = 64'h0;
    exp_w[5] = 64'h0000_0000_0000_0001;
    nw = 6;
    ysz_m = 2;
  endtask

  task automatic rand_a();
    for (int i = 0; i < 8; i++) row_a[32*i +: 32] = $urandom();
    for (int i = 0; i < 4; i++) col_a[32*i +: 32] = $urandom();
  endtask

  // One dump on dut_a. ready drops for stall_len cycles while word stall_at is
  // presented. With disturb set, inputs change and start pulses during COL.
  // done_cyc = cycles after the accepting edge at which done is seen (-1 if never).
  task automatic dump_a(input int stall_at, input int stall_len, input bit disturb,
                        output int done_cyc);
    int got = 0;
    int stalled = 0;
    bit prev_stall = 0;
    logic [63:0] prev_d = '0;
    logic prev_sel = 1'b0;
    logic prev_last = 1'b0;
    done_cyc = -1;
    bus_a.dout_ready = 1'b1;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    for (int cyc = 1; cyc < 60; cyc++) begin
      if (done_a) begin
        done_cyc = cyc;
        check("done_busy", 64'(busy_a), 64'd1);
        check("done_count", 64'(got), 64'(nw));
        break;
      end
      check("valid", 64'(bus_a.dout_valid), 64'd1);
      check("busy", 64'(busy_a), 64'd1);
      if (bus_a.dout_valid) begin
        check("word", bus_a.dout, exp_w[got]);
        check("sel", 64'(bus_a.dout_sel), 64'(got >= ysz_m));
        check("last", 64'(bus_a.dout_last), 64'(got == nw - 1));
        if (prev_stall) begin
          check("stall_dout", bus_a.dout, prev_d);
          check("stall_sel", 64'(bus_a.dout_sel), 64'(prev_sel));
          check("stall_last", 64'(bus_a.dout_last), 64'(prev_last));
        end
      end
      if (disturb) begin
        if (cyc == 1) begin
          start_a = 1'b1;
          col_a = ~col_a;
          row_a = ~row_a;
        end else begin
          start_a = 1'b0;
        end
      end
      if (got == stall_at && stalled < stall_len) begin
        bus_a.dout_ready = 1'b0;
        stalled++;
      end else begin
        bus_a.dout_ready = 1'b1;
      end
      prev_stall = !bus_a.dout_ready;
      prev_d = bus_a.dout;
      prev_sel = bus_a.dout_sel;
      prev_last = bus_a.dout_last;
      if (bus_a.dout_valid && bus_a.dout_ready) got++;
      @(negedge clk);
    end
    start_a = 1'b0;
    bus_a.dout_ready = 1'b1;
  endtask

  initial begin
    int dc;
    int got_b;
    int done_b_cyc;
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    row_a = '0;
    col_a = '0;
    row_b = '0;
    col_b = '0;
    bus_a.dout_ready = 1'b1;
    bus_b.dout_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_dout", bus_a.dout, 64'h0);
    check("rst_valid", 64'(bus_a.dout_valid), 64'd0);
    check("rst_sel", 64'(bus_a.dout_sel), 64'd0);
    check("rst_last", 64'(bus_a.dout_last), 64'd0);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_done", 64'(done_a), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic packing
    set_basic();
    dump_a(99, 0, 1'b0, dc);
    check("basic_done_cyc", 64'(dc), 64'd7);
    @(negedge clk);
    check("basic_busy_low", 64'(busy_a), 64'd0);
    $display("basic packing dump: done at cycle %0d", dc);

    // Dropped bit and corner
    row_a = '1;
    col_a = '0;
    exp_w[0] = 64'h0;
    exp_w[1] = 64'h0;
    exp_w[2] = 64'h7FFF_FFFF_FFFF_FFFF;
    exp_w[3] = 64'hFFFF_FFFF_FFFF_FFFF;
    exp_w[4] = 64'hFFFF_FFFF_FFFF_FFFF;
    exp_w[5] = 64'hFFFF_FFFF_FFFF_FFFF;
    nw = 6;
    ysz_m = 2;
    dump_a(99, 0, 1'b0, dc);
    check("corner_done_cyc", 64'(dc), 64'd7);
    $display("corner dump: done at cycle %0d", dc);

    // Backpressure on c[1]
    set_basic();
    dump_a(1, 3, 1'b0, dc);
    check("stall_done_cyc", 64'(dc), 64'd10);
    $display("backpressure dump: done at cycle %0d", dc);

    // Snapshot and start-while-busy
    rand_a();
    model(64, 256, 128, row_a, {128'b0, col_a});
    dump_a(99, 0, 1'b1, dc);
    check("snap_done_cyc", 64'(dc), 64'd7);
    repeat (3) begin
      @(negedge clk);
      check("snap_no_redump_valid", 64'(bus_a.dout_valid), 64'd0);
      check("snap_no_redump_busy", 64'(busy_a), 64'd0);
    end
    $display("snapshot dump: done at cycle %0d", dc);

    // Mid-dump reset after two handshakes
    set_basic();
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_word_before_rst", bus_a.dout, exp_w[2]);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(bus_a.dout_valid), 64'd0);
    check("mid_rst_busy", 64'(busy_a), 64'd0);
    check("mid_rst_done", 64'(done_a), 64'd0);
    @(negedge clk); rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("mid_no_done", 64'(done_a), 64'd0);
    end
    dump_a(99, 0, 1'b0, dc);
    check("mid_restart_done_cyc", 64'(dc), 64'd7);
    $display("reset mid-dump then restart: done at cycle %0d", dc);

    // Random vectors with random stalls
    for (int t = 0; t < 3; t++) begin
      int sa;
      int sl;
      rand_a();
      model(64, 256, 128, row_a, {128'b0, col_a});
      sa = int'($urandom_range(0, 5));
      sl = int'($urandom_range(0, 2));
      dump_a(sa, sl, 1'b0, dc);
      check("rand_done_cyc", 64'(dc), 64'(7 + sl));
      $display("random dump %0d: stall %0d cycles at word %0d, done at cycle %0d", t, sl, sa, dc);
    end

    // Non-default parameters: BS=32, N=96, L=64
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 3; i++) row_b[32*i +: 32] = $urandom();
      for (int i = 0; i < 2; i++) col_b[32*i +: 32] = $urandom();
      model(32, 96, 64, {160'b0, row_b}, {192'b0, col_b});
      got_b = 0;
      done_b_cyc = -1;
      @(negedge clk); start_b = 1'b1;
      @(negedge clk); start_b = 1'b0;
      for (int cyc = 1; cyc < 30; cyc++) begin
        if (done_b) begin
          done_b_cyc = cyc;
          break;
        end
        if (bus_b.dout_valid) begin
          check("b_word", 64'(bus_b.dout), exp_w[got_b]);
          check("b_sel", 64'(bus_b.dout_sel), 64'(got_b >= ysz_m));
          check("b_last", 64'(bus_b.dout_last), 64'(got_b == nw - 1));
          got_b++;
        end
        @(negedge clk);
      end
      check("b_count", 64'(got_b), 64'd5);
      check("b_done_cyc", 64'(done_b_cyc), 64'd6);
      $display("small-parameter dump %0d: %0d words, done at cycle %0d", t, got_b, done_b_cyc);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
